inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Transmit-side counterpart of the instruction decoder: packs ALU opcode and two register-select fields into 16-bit instruction words.
- Buffers packed words in a small FIFO and streams them to the decode stage over a valid/ready handshake.
- Optionally places an even-parity bit in bit 15 so the decode side can check word integrity.
- Sits between the instruction source (sequencer/testbench driver) and the decoder.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PARITY_EN, 1, 1 = bit 15 carries even parity over [14:0]; 0 = bit 15 driven 0.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  source presents fields this cycle.
- o_ready  output  1  encoder can accept; equals !full; registered and independent of i_ready.
- i_aluOp  input  9  ALU opcode field.
- i_in1  input  3  operand-1 select.
- i_in2  input  3  operand-2 select.
- o_inst  output  16  packed instruction at the FIFO head; 16'h0000 when o_valid=0.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  downstream accepts o_inst this cycle.
- o_level  output  log2(DEPTH)+1  current FIFO occupancy.
- o_issued  output  CNT_W  count of completed output transfers.

Behaviour:
- Encoding: inst[14:6]=i_aluOp, inst[5:3]=i_in1, inst[2:0]=i_in2.
  - PARITY_EN=1: inst[15] = XOR of inst[14:0], so the 16-bit word has even parity.
  - PARITY_EN=0: inst[15]=0.
  - The encoded word is computed at push time and stored in the FIFO.
- Push: i_valid && o_ready.
- Pop: o_valid && i_ready.
- Both push and pop are evaluated on the same edge. o_level updates +1, -1, or 0 (push and pop together leave it unchanged).
- Full (o_level==DEPTH): o_ready=0. i_valid is ignored and the fields are not captured. Pop still allowed.
- Empty: o_valid=0 and o_inst=0. A pop request is ignored.
- A push into an empty FIFO asserts o_valid on the next cycle (latency 1). Empty FIFO has no same-cycle bypass.
- Pushing and popping when full: the pop proceeds, the push is refused because o_ready=0 in that cycle, and o_ready rises next cycle.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Ordering is strict FIFO.
- o_issued increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- Reset (i_rst_n=0 at an edge), including mid-stream:
  - clears pointers; o_level=0, o_valid=0, o_inst=0, o_issued=0, o_ready=1 in the cycle after the reset edge.
  - discards buffered entries.
  - any push or pop in the reset cycle is ignored.
- FIFO storage need not be cleared.
- o_ready, o_valid, o_level, and o_issued are derived from registers only.

Test Plan:
- Single word, PARITY_EN=1: push aluOp=9'h1A5, in1=5, in2=2 with i_ready=1.
  - Required: next cycle o_valid=1, o_inst=16'h696A.
  - Then o_valid=0, o_issued=1.
- Parity bit: push aluOp=9'h001, in1=0, in2=0.
  - PARITY_EN=1: o_inst=16'h8040.
  - PARITY_EN=0: o_inst=16'h0040.
- Fill/backpressure, DEPTH=4, i_ready=0: push 5 distinct words on consecutive cycles.
  - Required: o_ready=0 after the 4th push, 5th word dropped, o_level=4.
  - Raise i_ready: words 1–4 emerge in order, o_level counts down to 0, o_issued=4.
- Simultaneous push/pop: with o_level=2 and i_valid=i_ready=1 for 6 cycles.
  - Required: o_level stays 2 throughout, output order matches input order.
  - Pointers wrap with no loss or duplication.
- Reset mid-operation: with o_level=3, drive i_rst_n=0 for one edge while i_valid=1.
  - Required: next cycle o_level=0, o_valid=0, o_inst=0, o_issued=0, o_ready=1.
  - The word presented during reset is not stored.
- Counter wrap, CNT_W=4: complete 16 transfers.
  - Required: o_issued reads 15 after the 15th pop and 0 after the 16th.

Source files
------------

// File: rtl/inst_encoder.sv
// Instruction encoder: packs ALU opcode and two register selects into a
// 16-bit word (optional even parity in bit 15), buffers the words in a small
// FIFO and streams them to the decode stage over a valid/ready handshake.
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [8:0]               i_aluOp,
  input  logic [2:0]               i_in1,
  input  logic [2:0]               i_in2,
  output logic [15:0]              o_inst,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_issued
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  logic [14:0]      payload;
  logic [15:0]      enc_word;
  logic             push;
  logic             pop;

  // Pack the fields and attach the parity bit at push time
  always_comb begin
    payload  = {i_aluOp, i_in1, i_in2};
    enc_word = {(PARITY_EN ? ^payload : 1'b0), payload};
  end

  // Handshake qualification uses only registered status flags
  always_comb begin
    push = i_valid && ready_q;
    pop  = valid_q && i_ready;
  end

  // Next-state for pointers, occupancy, status flags and issue counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    issued_d = issued_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      issued_d = issued_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Flags are precomputed from the next occupancy so they leave the block
    // straight from flops rather than through a comparator.
    ready_d = (level_d != LVL_W'(DEPTH));
    valid_d = (level_d != '0);
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      issued_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
    end
  end

  // FIFO storage write; contents are not cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  // Head-of-FIFO output, forced to zero while empty
  always_comb begin
    o_inst   = valid_q ? mem_q[rd_ptr_q] : '0;
    o_ready  = ready_q;
    o_valid  = valid_q;
    o_level  = level_q;
    o_issued = issued_q;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: two instances share stimulus, one with parity
// and a 4-bit issue counter, one without parity and a 16-bit counter. A
// queue-based reference model predicts every output after each clock edge.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [8:0]  alu;
  logic [2:0]  in1;
  logic [2:0]  in2;

  logic        a_ready, a_valid;
  logic [15:0] a_inst;
  logic [2:0]  a_level;
  logic [3:0]  a_issued;

  logic        b_ready, b_valid;
  logic [15:0] b_inst;
  logic [2:0]  b_level;
  logic [15:0] b_issued;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] q[$];
  int          issued_cnt = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .PARITY_EN(1'b1), .CNT_W(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready),
    .i_aluOp(alu), .i_in1(in1), .i_in2(in2), .o_inst(a_inst),
    .o_valid(a_valid), .i_ready(ready), .o_level(a_level), .o_issued(a_issued)
  );

  inst_encoder #(.DEPTH(DEPTH), .PARITY_EN(1'b0), .CNT_W(16)) u_dut_np (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready),
    .i_aluOp(alu), .i_in1(in1), .i_in2(in2), .o_inst(b_inst),
    .o_valid(b_valid), .i_ready(ready), .o_level(b_level), .o_issued(b_issued)
  );

  // Expected word with even parity, built arithmetically from the fields
  function automatic logic [15:0] expect_word(input int a, input int b, input int c);
    int payload;
    int par;
    payload = a * 64 + b * 8 + c;
    par = $countones(payload) % 2;
    return 16'(par * 32768 + payload);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int lvl;
    logic [15:0] head;
    lvl  = q.size();
    head = (lvl != 0) ? q[0] : 16'h0000;
    chk({tag, ".a_level"},  32'(a_level),  32'(lvl));
    chk({tag, ".a_valid"},  32'(a_valid),  32'(lvl != 0));
    chk({tag, ".a_ready"},  32'(a_ready),  32'(lvl != DEPTH));
    chk({tag, ".a_inst"},   32'(a_inst),   32'(head));
    chk({tag, ".a_issued"}, 32'(a_issued), 32'(issued_cnt % 16));
    chk({tag, ".b_level"},  32'(b_level),  32'(lvl));
    chk({tag, ".b_inst"},   32'(b_inst),   32'(head & 16'h7FFF));
    chk({tag, ".b_issued"}, 32'(b_issued), 32'(issued_cnt % 65536));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare
  task automatic step(input string tag, input logic v, input logic r,
                      input int a, input int b, input int c, input logic rst);
    bit do_push, do_pop;
    valid = v; ready = r; alu = 9'(a); in1 = 3'(b); in2 = 3'(c); rst_n = rst;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      issued_cnt = 0;
    end else begin
      do_pop  = (q.size() != 0) && r;
      do_push = v && (q.size() != DEPTH);
      if (do_pop) begin
        void'(q.pop_front());
        issued_cnt++;
      end
      if (do_push) q.push_back(expect_word(a, b, c));
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    valid = 0; ready = 0; alu = '0; in1 = '0; in2 = '0; rst_n = 0;

    // Reset
    step("reset0", 0, 0, 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0, 0, 0);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_level", 32'(a_level), 32'd0);

    // Single word with parity
    step("single_push", 1, 1, 'h1A5, 5, 2, 1);
    chk("single_inst", 32'(a_inst), 32'h696A);
    chk("single_valid", 32'(a_valid), 32'd1);
    step("single_pop", 0, 1, 0, 0, 0, 1);
    chk("single_empty", 32'(a_valid), 32'd0);
    chk("single_issued", 32'(a_issued), 32'd1);

    // Parity bit on/off
    step("par_push", 1, 0, 'h001, 0, 0, 1);
    chk("par_inst_en", 32'(a_inst), 32'h8040);
    chk("par_inst_dis", 32'(b_inst), 32'h0040);
    step("par_pop", 0, 1, 0, 0, 0, 1);

    // Fill with backpressure: 5th word dropped
    for (int i = 0; i < 5; i++)
      step("fill", 1, 0, 'h010 + i, i, 7 - i, 1);
    chk("fill_ready", 32'(a_ready), 32'd0);
    chk("fill_level", 32'(a_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(a_inst), 32'(expect_word('h010 + i, i, 7 - i)));
      step("drain", 0, 1, 0, 0, 0, 1);
    end
    chk("drain_level", 32'(a_level), 32'd0);
    chk("drain_issued", 32'(b_issued), 32'd6);

    // Simultaneous push/pop at level 2, pointers wrap
    step("sim_pre0", 1, 0, 'h0AA, 1, 1, 1);
    step("sim_pre1", 1, 0, 'h155, 2, 2, 1);
    for (int i = 0; i < 6; i++) begin
      step("sim", 1, 1, $urandom_range(511), $urandom_range(7), $urandom_range(7), 1);
      chk("sim_level", 32'(a_level), 32'd2);
    end
    step("sim_drain0", 0, 1, 0, 0, 0, 1);
    step("sim_drain1", 0, 1, 0, 0, 0, 1);

    // Reset mid-operation with a word presented
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1, 0, 'h100 + i, 3, 4, 1);
    step("rst_mid", 1, 1, 'h1FF, 7, 7, 0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_inst", 32'(a_inst), 32'd0);
    chk("rst_issued", 32'(b_issued), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    step("rst_after", 0, 0, 0, 0, 0, 1);
    chk("rst_not_stored", 32'(a_valid), 32'd0);

    // 4-bit issue counter wrap
    for (int i = 0; i < 16; i++) begin
      step("wrap_push", 1, 0, $urandom_range(511), $urandom_range(7), $urandom_range(7), 1);
      step("wrap_pop", 0, 1, 0, 0, 0, 1);
      chk("wrap_issued", 32'(a_issued), 32'((i + 1) % 16));
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(511), $urandom_range(7), $urandom_range(7),
           ($urandom_range(63) != 0));

    for (int i = 0; i < DEPTH; i++)
      step("final_drain", 0, 1, 0, 0, 0, 1);
    chk("final_empty", 32'(a_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
